// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and feeder state encoding
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_FIFO_DEPTH = 8;

    typedef enum logic [1:0] {
        FEEDER_IDLE    = 2'd0,
        FEEDER_START   = 2'd1,
        FEEDER_SENDING = 2'd2
    } feeder_state_t;

endpackage

// File: rtl/tx_fifo_mem.sv
// rtl/tx_fifo_mem.sv - circular transmit buffer with occupancy count and flags
module tx_fifo_mem
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int FIFO_DEPTH = UART_FIFO_DEPTH
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               flush,
    input  logic                               wr_en,
    input  logic [DATA_BITS-1:0]               wr_data,
    input  logic                               pop,
    output logic [DATA_BITS-1:0]               rd_data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    count,
    output logic                               full,
    output logic                               empty,
    output logic                               overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count_next;
    logic                 do_pop;
    logic                 do_wr;
    logic                 drop;

    // A pop frees the slot under the write pointer, so a full FIFO can still accept.
    assign do_pop = pop && !empty && !flush;
    assign do_wr  = wr_en && !flush && (!full || do_pop);
    assign drop   = wr_en && !flush && full && !do_pop;

    assign rd_data = mem[rd_ptr];

    always_comb begin
        count_next = count;
        case ({do_wr, do_pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_next;
            full  <= (count_next == CNT_W'(FIFO_DEPTH));
            empty <= (count_next == '0);
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - buffers host bytes and launches them one at a time into the UART transmitter
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DATA_BITS     = UART_DATA_BITS,
    parameter int FIFO_DEPTH    = UART_FIFO_DEPTH,
    parameter int START_TIMEOUT = 4096
) (
    input  logic                               SysClk,
    input  logic                               Rst,
    input  logic                               Wr_En,
    input  logic [DATA_BITS-1:0]               Wr_Data,
    input  logic                               Flush,
    input  logic                               Tx_Busy,
    output logic [DATA_BITS-1:0]               Tx_Data,
    output logic                               Transmit_Start,
    output logic                               FIFO_Full,
    output logic                               FIFO_Empty,
    output logic                               FIFO_Overflow,
    output logic                               Start_Error,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    Count,
    output logic                               Feeder_Busy
);

    localparam logic [1:0] IDLE    = FEEDER_IDLE;
    localparam logic [1:0] START   = FEEDER_START;
    localparam logic [1:0] SENDING = FEEDER_SENDING;

    localparam int TMR_W = $clog2(START_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(START_TIMEOUT - 1);

    logic [1:0]           state;
    logic [TMR_W-1:0]     timer;
    logic [DATA_BITS-1:0] fifo_rd_data;
    logic                 pop;
    logic                 start_timeout;

    // Flush owns the FIFO for its cycle, so no pop is taken alongside it.
    assign pop           = (state == IDLE) && !FIFO_Empty && !Flush;
    assign start_timeout = (state == START) && !Tx_Busy && (timer == TMR_LAST);

    tx_fifo_mem #(
        .DATA_BITS  (DATA_BITS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (SysClk),
        .rst_n    (Rst),
        .flush    (Flush),
        .wr_en    (Wr_En),
        .wr_data  (Wr_Data),
        .pop      (pop),
        .rd_data  (fifo_rd_data),
        .count    (Count),
        .full     (FIFO_Full),
        .empty    (FIFO_Empty),
        .overflow (FIFO_Overflow)
    );

    always_ff @(posedge SysClk or negedge Rst) begin
        if (!Rst) begin
            state          <= IDLE;
            timer          <= '0;
            Tx_Data        <= '0;
            Transmit_Start <= 1'b0;
            Feeder_Busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        Tx_Data        <= fifo_rd_data;
                        Transmit_Start <= 1'b1;
                        Feeder_Busy    <= 1'b1;
                        timer          <= '0;
                        state          <= START;
                    end
                end
                START: begin
                    if (Tx_Busy) begin
                        Transmit_Start <= 1'b0;
                        state          <= SENDING;
                    end else if (start_timeout) begin
                        // Transmitter never acknowledged: drop this byte and move on.
                        Transmit_Start <= 1'b0;
                        Feeder_Busy    <= 1'b0;
                        state          <= IDLE;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                SENDING: begin
                    if (!Tx_Busy) begin
                        Feeder_Busy <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    Transmit_Start <= 1'b0;
                    Feeder_Busy    <= 1'b0;
                    state          <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge SysClk or negedge Rst) begin
        if (!Rst) begin
            Start_Error <= 1'b0;
        end else if (Flush) begin
            Start_Error <= 1'b0;
        end else if (start_timeout) begin
            Start_Error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb/tb_uart_tx_feeder.sv - randomized and directed self-checking bench for uart_tx_feeder
module tb_uart_tx_feeder;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int TMO   = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          flush;
    logic          tx_busy;
    logic [DW-1:0] tx_data;
    logic          transmit_start;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_overflow;
    logic          start_error;
    logic [CW-1:0] count;
    logic          feeder_busy;

    int vectors     = 0;
    int miscompares = 0;

    // Transmitter model: mode 1 drives tx_force, mode 0 acknowledges starts with random timing.
    int          tx_mode  = 1;
    logic        tx_force = 1'b0;
    int          busy_left = 0;
    int          ack_dly   = 0;

    logic [7:0]  cap_q[$];
    int          start_pulses = 0;
    logic        mon_prev = 1'b0;

    logic [7:0]  exp_q[$];
    int          base;
    int          pulses0;
    int          n;
    int          written;
    int          cyc;

    uart_tx_feeder #(
        .DATA_BITS     (DW),
        .FIFO_DEPTH    (DEPTH),
        .START_TIMEOUT (TMO)
    ) dut (
        .SysClk         (clk),
        .Rst            (rst_n),
        .Wr_En          (wr_en),
        .Wr_Data        (wr_data),
        .Flush          (flush),
        .Tx_Busy        (tx_busy),
        .Tx_Data        (tx_data),
        .Transmit_Start (transmit_start),
        .FIFO_Full      (fifo_full),
        .FIFO_Empty     (fifo_empty),
        .FIFO_Overflow  (fifo_overflow),
        .Start_Error    (start_error),
        .Count          (count),
        .Feeder_Busy    (feeder_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int k;
        k = 0;
        while ((feeder_busy || !fifo_empty || tx_busy) && k < 2000) begin
            tick();
            k++;
        end
        if (k >= 2000) check(tag, 32'd0, 32'd1);
    endtask

    task automatic check_reset_vals();
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(fifo_empty), 32'd1);
        check("rst_full", 32'(fifo_full), 32'd0);
        check("rst_ovf", 32'(fifo_overflow), 32'd0);
        check("rst_err", 32'(start_error), 32'd0);
        check("rst_fbusy", 32'(feeder_busy), 32'd0);
        check("rst_start", 32'(transmit_start), 32'd0);
        check("rst_txdata", 32'(tx_data), 32'd0);
    endtask

    // Byte monitor: every rising Transmit_Start launches the byte on Tx_Data.
    initial begin
        forever begin
            @(negedge clk);
            if (transmit_start && !mon_prev) begin
                cap_q.push_back(tx_data);
                start_pulses++;
            end
            mon_prev = transmit_start;
        end
    end

    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                tx_busy   = 1'b0;
                busy_left = 0;
                ack_dly   = 0;
            end else if (tx_mode == 1) begin
                tx_busy = tx_force;
            end else if (tx_busy) begin
                if (busy_left == 0) tx_busy = 1'b0;
                else busy_left--;
            end else if (transmit_start) begin
                if (ack_dly == 0) begin
                    tx_busy   = 1'b1;
                    busy_left = $urandom_range(5, 1);
                    ack_dly   = $urandom_range(2, 0);
                end else begin
                    ack_dly--;
                end
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        flush   = 1'b0;
        tick(); tick(); tick();
        check_reset_vals();
        rst_n = 1'b1;
        tick();

        // Single byte, manual handshake
        pulses0 = start_pulses;
        write_byte(8'hA5);
        check("t1_count1", 32'(count), 32'd1);
        check("t1_start_early", 32'(transmit_start), 32'd0);
        tick();
        check("t1_count0", 32'(count), 32'd0);
        check("t1_start_rise", 32'(transmit_start), 32'd1);
        check("t1_txdata", 32'(tx_data), 32'hA5);
        check("t1_fbusy", 32'(feeder_busy), 32'd1);
        tick(); tick(); tick();
        check("t1_start_hold", 32'(transmit_start), 32'd1);
        tx_force = 1'b1;
        tick();
        check("t1_start_fall", 32'(transmit_start), 32'd0);
        tx_force = 1'b0;
        tick();
        check("t1_fbusy_idle", 32'(feeder_busy), 32'd0);
        check("t1_pulses", 32'(start_pulses - pulses0), 32'd1);
        check("t1_cap", 32'(cap_q[cap_q.size()-1]), 32'hA5);

        // Burst into a stalled transmitter, then overflow
        tx_mode  = 1;
        tx_force = 1'b1;
        tick();
        base = cap_q.size();
        for (int i = 1; i <= 8; i++) write_byte(8'(i));
        check("t2_count7", 32'(count), 32'd7);
        check("t2_notfull", 32'(fifo_full), 32'd0);
        write_byte(8'h09);
        check("t2_count8", 32'(count), 32'd8);
        check("t2_full", 32'(fifo_full), 32'd1);
        check("t2_noovf", 32'(fifo_overflow), 32'd0);
        write_byte(8'h0A);
        check("t2_ovf", 32'(fifo_overflow), 32'd1);
        check("t2_count_hold", 32'(count), 32'd8);
        tx_mode = 0;
        wait_drain("t2_drain_timeout");
        check("t2_ncap", 32'(cap_q.size() - base), 32'd9);
        for (int i = 0; i < 9 && base + i < cap_q.size(); i++)
            check("t2_order", 32'(cap_q[base+i]), 32'(i + 1));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t2_flush_ovf", 32'(fifo_overflow), 32'd0);

        // Write into a full FIFO during the pop cycle
        tx_mode  = 1;
        tx_force = 1'b1;
        tick();
        write_byte(8'h10);
        tick(); tick();
        base = cap_q.size();
        for (int i = 0; i < 8; i++) write_byte(8'(8'h11 + i));
        check("t3_full", 32'(fifo_full), 32'd1);
        check("t3_count8", 32'(count), 32'd8);
        tx_force = 1'b0;
        tick();
        check("t3_idle", 32'(feeder_busy), 32'd0);
        wr_en   = 1'b1;
        wr_data = 8'h55;
        tx_mode = 0;
        tick();
        wr_en = 1'b0;
        check("t3_count_kept", 32'(count), 32'd8);
        check("t3_noovf", 32'(fifo_overflow), 32'd0);
        wait_drain("t3_drain_timeout");
        exp_q = {8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h55};
        check("t3_ncap", 32'(cap_q.size() - base), 32'd9);
        for (int i = 0; i < 9 && base + i < cap_q.size(); i++)
            check("t3_order", 32'(cap_q[base+i]), 32'(exp_q[i]));

        // Start timeout
        tx_mode  = 1;
        tx_force = 1'b0;
        tick();
        write_byte(8'h3C);
        tick();
        check("t4_txdata", 32'(tx_data), 32'h3C);
        n = 0;
        while (transmit_start && n < 40) begin
            n++;
            tick();
        end
        check("t4_start_len", 32'(n), 32'(TMO));
        check("t4_err", 32'(start_error), 32'd1);
        check("t4_idle", 32'(feeder_busy), 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t4_err_clr", 32'(start_error), 32'd0);

        // Asynchronous reset during SENDING
        tx_force = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) write_byte(8'(8'h40 + i));
        tick();
        check("t5_count3", 32'(count), 32'd3);
        check("t5_sending", 32'(feeder_busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals();
        tx_force = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        pulses0 = start_pulses;
        for (int i = 0; i < 5; i++) tick();
        check("t5_no_start", 32'(start_pulses - pulses0), 32'd0);
        check("t5_count0", 32'(count), 32'd0);
        tx_mode = 0;
        write_byte(8'h66);
        wait_drain("t5_drain_timeout");
        check("t5_one_start", 32'(start_pulses - pulses0), 32'd1);
        check("t5_cap", 32'(cap_q[cap_q.size()-1]), 32'h66);

        // Flush with a simultaneous write during SENDING
        tx_mode  = 1;
        tx_force = 1'b1;
        tick();
        base = cap_q.size();
        for (int i = 0; i < 6; i++) write_byte(8'(8'h20 + i));
        check("t6_count5", 32'(count), 32'd5);
        flush   = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'h77;
        tick();
        flush = 1'b0;
        wr_en = 1'b0;
        check("t6_count0", 32'(count), 32'd0);
        check("t6_empty", 32'(fifo_empty), 32'd1);
        check("t6_noovf", 32'(fifo_overflow), 32'd0);
        check("t6_inflight", 32'(feeder_busy), 32'd1);
        tx_mode = 0;
        wait_drain("t6_drain_timeout");
        for (int i = 0; i < 10; i++) tick();
        check("t6_ncap", 32'(cap_q.size() - base), 32'd1);
        check("t6_cap", 32'(cap_q[base]), 32'h20);

        // Randomized traffic against an in-order byte queue
        tx_mode = 0;
        exp_q.delete();
        base    = cap_q.size();
        written = 0;
        cyc     = 0;
        while (written < 60 && cyc < 5000) begin
            if ((written - (cap_q.size() - base)) < DEPTH && $urandom_range(1, 0) == 1) begin
                wr_en   = 1'b1;
                wr_data = 8'($urandom);
                exp_q.push_back(wr_data);
                written++;
            end else begin
                wr_en = 1'b0;
            end
            tick();
            cyc++;
        end
        wr_en = 1'b0;
        wait_drain("rnd_drain_timeout");
        check("rnd_ncap", 32'(cap_q.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && base + i < cap_q.size(); i++)
            check("rnd_byte", 32'(cap_q[base+i]), 32'(exp_q[i]));
        check("rnd_count0", 32'(count), 32'd0);
        check("rnd_noovf", 32'(fifo_overflow), 32'd0);
        check("rnd_noerr", 32'(start_error), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
